// File: rtl/ecc_result_collector_pkg.sv
// Shared constants for the ECC result collector: default sizes and the
// error-code values reported by the encoder/decoder top.
package ecc_result_collector_pkg;

  localparam int DEPTH_DEFAULT     = 4;
  localparam int CNT_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    NOE_NONE = 2'b00,
    NOE_ONE  = 2'b01,
    NOE_TWO  = 2'b10
  } noe_t;

  // Codes 10 and 11 both mean the word could not be corrected.
  function automatic logic is_uncorrectable(input logic [1:0] code);
    return (code == NOE_TWO) || (code == 2'b11);
  endfunction

  function automatic logic is_corrected(input logic [1:0] code);
    return code == NOE_ONE;
  endfunction

endpackage

// File: rtl/ecc_result_if.sv
// Show-ahead result stream from the collector to its consumer.
interface ecc_result_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic [1:0]            res_errors;

  modport master (
    output res_valid,
    output res_data,
    output res_errors,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_errors,
    output res_ready
  );
endinterface

// File: rtl/ecc_sat_counter.sv
// Statistics counter that sticks at all-ones; clear wins over the old
// value but a same-cycle increment still counts.
module ecc_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= {{(CNT_WIDTH-1){1'b0}}, inc};
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ecc_result_collector.sv
// Captures each completed encoder/decoder result into a small show-ahead
// FIFO and keeps saturating statistics on the reported error codes.
module ecc_result_collector
  import ecc_result_collector_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = DEPTH_DEFAULT,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   data_out,
  input  logic                    operation_done,
  input  logic [1:0]              num_of_errors,
  input  logic                    clear_stats,
  ecc_result_if.master            res,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic                    overflow,
  output logic [CNT_WIDTH-1:0]    cnt_total,
  output logic [CNT_WIDTH-1:0]    cnt_corrected,
  output logic [CNT_WIDTH-1:0]    cnt_uncorr
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH+1:0] mem [DEPTH];
  logic [DATA_WIDTH+1:0] head;
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  op_done_q;
  logic                  capture;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  full;
  logic                  empty;

  assign capture = operation_done && !op_done_q;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && res.res_ready;
  // A pop in the same cycle frees the slot a full-FIFO capture needs.
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_done_q <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      op_done_q <= operation_done;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {num_of_errors, data_out};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (clear_stats) begin
      overflow <= drop;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign head           = mem[rd_ptr[AW-1:0]];
  assign res.res_valid  = !empty;
  assign res.res_data   = empty ? '0 : head[DATA_WIDTH-1:0];
  assign res.res_errors = empty ? 2'b00 : head[DATA_WIDTH+1:DATA_WIDTH];
  assign fill_level     = wr_ptr - rd_ptr;

  ecc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_total (
    .clk (clk),
    .rst (rst),
    .inc (capture),
    .clr (clear_stats),
    .cnt (cnt_total)
  );

  ecc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_corrected (
    .clk (clk),
    .rst (rst),
    .inc (capture && is_corrected(num_of_errors)),
    .clr (clear_stats),
    .cnt (cnt_corrected)
  );

  ecc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_uncorr (
    .clk (clk),
    .rst (rst),
    .inc (capture && is_uncorrectable(num_of_errors)),
    .clr (clear_stats),
    .cnt (cnt_uncorr)
  );

endmodule

// File: doc/ecc_result_collector.md
ECC_RESULT_COLLECTOR -- requirements
Module: ecc_result_collector

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of the result data word.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of result FIFO entries (power of two, >=2).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of each statistics counter.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 data_out  input  DATA_WIDTH  result word from the encoder/decoder top.
REQ-007 operation_done  input  1  completion flag from the encoder/decoder top (registered there).
REQ-008 num_of_errors  input  2  error count from the top: 00 none, 01 one (corrected), 10/11 two (uncorrectable).
REQ-009 clear_stats  input  1  synchronous clear of counters and sticky overflow.
REQ-010 res_valid  output  1  FIFO head holds a result.
REQ-011 res_ready  input  1  consumer accepts the head.
REQ-012 res_data  output  DATA_WIDTH  head result word.
REQ-013 res_errors  output  2  head error code.
REQ-014 fill_level  output  log2(DEPTH)+1  number of occupied entries.
REQ-015 overflow  output  1  sticky: a result was dropped.
REQ-016 cnt_total, cnt_corrected, cnt_uncorr  output  CNT_WIDTH each  statistics counters.

Function
REQ-017 Capture SHALL occur in a cycle where operation_done=1 and its registered previous value=0 (rising edge only); a level held high for N cycles SHALL yield one capture.
REQ-018 On capture, {num_of_errors, data_out} sampled in that same cycle SHALL be written to the tail entry.
REQ-019 The FIFO SHALL be show-ahead: res_valid = (fill_level != 0); res_data/res_errors SHALL reflect the head combinationally from storage with no extra latency.
REQ-020 A pop SHALL occur when res_valid and res_ready are both 1; res_ready while empty SHALL have no effect.
REQ-021 Latency: a result captured in cycle N SHALL be visible at the head with res_valid=1 in cycle N+1 if the FIFO was empty.
REQ-022 Read and write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full = equal index bits with differing MSB, empty = equal pointers.
REQ-023 Capture while full without a same-cycle pop SHALL be dropped, leaving FIFO contents unchanged, and SHALL set overflow.
REQ-024 Capture while full with a same-cycle pop SHALL be accepted; fill_level SHALL stay at DEPTH.
REQ-025 Simultaneous capture and pop at any other level SHALL leave fill_level unchanged.
REQ-026 Every capture (accepted or dropped) SHALL increment cnt_total; also cnt_corrected if code 01, cnt_uncorr if code 10 or 11.
REQ-027 Counters SHALL saturate at all-ones and never wrap.
REQ-028 clear_stats SHALL zero all counters and overflow; if a capture occurs in the same cycle, the affected counters SHALL read 1 afterwards and overflow SHALL reflect only that cycle's drop.
REQ-029 clear_stats SHALL NOT affect FIFO contents or pointers.

Reset
REQ-030 On rst=0, the block SHALL asynchronously clear pointers, the operation_done edge register, counters and overflow; res_valid=0, fill_level=0; res_data/res_errors SHALL read 0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered results; the first capture after release requires a fresh 0->1 edge on operation_done.

Structure
REQ-032 A shared package SHALL hold DEPTH/CNT_WIDTH defaults and the error-code constants (NOE_NONE=00, NOE_ONE=01, NOE_TWO=10).
REQ-033 A sub-module ecc_sat_counter (CNT_WIDTH parameter, inc, clr, async active-low rst) SHALL be instantiated three times.

Verification
REQ-034 Reset, then operation_done pulse with data_out=0x0000_00A5, num_of_errors=01, res_ready=0 -> next cycle res_valid=1, res_data=0x0000_00A5, res_errors=01, cnt_total=1, cnt_corrected=1.
REQ-035 operation_done held high 5 cycles -> exactly one entry, cnt_total=1.
REQ-036 Six pulses (codes 00,01,10,11,00,01) with res_ready=0, DEPTH=4 -> fill_level=4, overflow=1, heads pop in order first four, cnt_total=6, cnt_corrected=2, cnt_uncorr=2.
REQ-037 FIFO full, capture with res_ready=1 same cycle -> fill_level stays 4, overflow stays 0, new word becomes last entry.
REQ-038 Force cnt_total to 0xFFFF (CNT_WIDTH=16) then capture -> stays 0xFFFF; clear_stats with same-cycle capture -> cnt_total=1.
REQ-039 Three entries buffered, assert rst=0 mid-pop -> res_valid=0, fill_level=0, all counters 0 immediately.
